// File: rtl/lowx_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache refills.
// Optional WAIT timeout watchdog enabled with `define LOWX_ARB_TIMEOUT_EN.
module lowx_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int BLK_W       = 128,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ireq_valid_i,
    output logic              ireq_ready_o,
    input  logic [ADDR_W-1:0] ireq_addr_i,
    input  logic              ireq_uncached_i,
    output logic              ires_valid_o,
    output logic [BLK_W-1:0]  ires_data_o,
    input  logic              iflush_i,
    input  logic              dreq_valid_i,
    output logic              dreq_ready_o,
    input  logic [ADDR_W-1:0] dreq_addr_i,
    input  logic              dreq_rw_i,
    input  logic [BLK_W-1:0]  dreq_data_i,
    input  logic              dreq_uncached_i,
    output logic              dres_valid_o,
    output logic [BLK_W-1:0]  dres_data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              mem_req_rw_o,
    output logic [BLK_W-1:0]  mem_req_data_o,
    output logic              mem_req_uncached_o,
    input  logic              mem_res_valid_i,
    input  logic [BLK_W-1:0]  mem_res_data_i,
    output logic              timeout_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic       OWN_I  = 1'b0;
    localparam logic       OWN_D  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [BLK_W-1:0]  data_q, data_d;
    logic              unc_q, unc_d;
    logic              drop_q, drop_d;
    logic              ires_valid_q, ires_valid_d;
    logic [BLK_W-1:0]  ires_data_q, ires_data_d;
    logic              dres_valid_q, dres_valid_d;
    logic [BLK_W-1:0]  dres_data_q, dres_data_d;

    logic              grant_i, grant_d;
    logic              resp_fire;
    logic [BLK_W-1:0]  resp_data;
    logic              drop_now;

`ifdef LOWX_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       terr_q, terr_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        data_d       = data_q;
        unc_d        = unc_q;
        ires_valid_d = 1'b0;
        ires_data_d  = ires_data_q;
        dres_valid_d = 1'b0;
        dres_data_d  = dres_data_q;
        ireq_ready_o = 1'b0;
        dreq_ready_o = 1'b0;
        mem_req_valid_o = 1'b0;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        resp_fire    = 1'b0;
        resp_data    = mem_res_data_i;
`ifdef LOWX_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        terr_d       = terr_q;
`endif
        // A flush arriving in the response cycle must still kill that response.
        drop_now = drop_q | (iflush_i && (owner_q == OWN_I) && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                grant_i = ireq_valid_i && (!dreq_valid_i || (last_grant_q == OWN_D));
                grant_d = dreq_valid_i && !grant_i;
                if (grant_i) begin
                    ireq_ready_o = 1'b1;
                    owner_d      = OWN_I;
                    last_grant_d = OWN_I;
                    addr_d       = ireq_addr_i;
                    rw_d         = 1'b0;
                    data_d       = '0;
                    unc_d        = ireq_uncached_i;
                    state_d      = S_REQ;
                end else if (grant_d) begin
                    dreq_ready_o = 1'b1;
                    owner_d      = OWN_D;
                    last_grant_d = OWN_D;
                    addr_d       = dreq_addr_i;
                    rw_d         = dreq_rw_i;
                    data_d       = dreq_data_i;
                    unc_d        = dreq_uncached_i;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    if (mem_res_valid_i) begin
                        resp_fire = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_WAIT;
                    end
`ifdef LOWX_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_res_valid_i) begin
                    resp_fire = 1'b1;
                    state_d   = S_IDLE;
`ifdef LOWX_ARB_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_LIM) begin
                    resp_fire = 1'b1;
                    resp_data = '0;
                    terr_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (resp_fire) begin
            if (owner_q == OWN_D) begin
                dres_valid_d = 1'b1;
                dres_data_d  = resp_data;
            end else if (!drop_now) begin
                ires_valid_d = 1'b1;
                ires_data_d  = resp_data;
            end
        end

        drop_d = (state_d == S_IDLE) ? 1'b0 : drop_now;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_D;
            owner_q      <= OWN_I;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            data_q       <= '0;
            unc_q        <= 1'b0;
            drop_q       <= 1'b0;
            ires_valid_q <= 1'b0;
            ires_data_q  <= '0;
            dres_valid_q <= 1'b0;
            dres_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            data_q       <= data_d;
            unc_q        <= unc_d;
            drop_q       <= drop_d;
            ires_valid_q <= ires_valid_d;
            ires_data_q  <= ires_data_d;
            dres_valid_q <= dres_valid_d;
            dres_data_q  <= dres_data_d;
        end
    end

`ifdef LOWX_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err_o = terr_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign mem_req_addr_o     = addr_q;
    assign mem_req_rw_o       = rw_q;
    assign mem_req_data_o     = data_q;
    assign mem_req_uncached_o = unc_q;
    assign ires_valid_o       = ires_valid_q;
    assign ires_data_o        = ires_data_q;
    assign dres_valid_o       = dres_valid_q;
    assign dres_data_o        = dres_data_q;

endmodule
